// File: rtl/frame_buffer_arbiter.sv
// Frame-buffer memory port arbiter. Display reads always win the slot, and CPU writes and the clear engine share the remaining slots round-robin.
// Defining FRAME_BUFFER_ARBITER_STATS_EN enables the CPU stall counter on STALL_COUNT; otherwise that port is tied to zero.
module frame_buffer_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 12,
  parameter int FB_DEPTH   = 19200
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  VGA_REQ,
  input  logic [ADDR_WIDTH-1:0] VGA_ADDR,
  output logic [DATA_WIDTH-1:0] VGA_DATA,
  output logic                  VGA_VALID,
  input  logic                  CPU_REQ,
  input  logic [ADDR_WIDTH-1:0] CPU_ADDR,
  input  logic [DATA_WIDTH-1:0] CPU_DATA,
  output logic                  CPU_GNT,
  output logic                  CPU_ERR,
  input  logic                  CLEAR_START,
  input  logic [DATA_WIDTH-1:0] CLEAR_COLOUR,
  output logic                  CLEAR_BUSY,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_WE,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  output logic [15:0]           STALL_COUNT
);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(FB_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state;
  logic                  ptr_clr;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] clr_colour;
  logic [1:0]            rd_pipe;
  logic                  clr_req;
  logic                  cpu_oob;
  logic                  cpu_win;
  logic                  clr_win;

  assign clr_req = (state == CLEAR);
  assign cpu_oob = ({1'b0, CPU_ADDR} >= DEPTH_EXT);
  // The grant is combinational so the CPU sees it in the winning cycle; it is gated by RESET so it drops at once.
  assign cpu_win = RESET && !VGA_REQ && CPU_REQ && (!clr_req || !ptr_clr);
  assign clr_win = !VGA_REQ && clr_req && (!CPU_REQ || ptr_clr);

  assign CPU_GNT    = cpu_win;
  assign CPU_ERR    = cpu_win && cpu_oob;
  assign CLEAR_BUSY = clr_req;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      ptr_clr    <= 1'b0;
      clr_cnt    <= '0;
      clr_colour <= '0;
      rd_pipe    <= '0;
      VGA_DATA   <= '0;
      VGA_VALID  <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WE     <= 1'b0;
      MEM_WDATA  <= '0;
    end else begin
      rd_pipe   <= {rd_pipe[0], VGA_REQ};
      VGA_VALID <= rd_pipe[1];
      if (rd_pipe[1]) VGA_DATA <= MEM_RDATA;

      MEM_WE <= 1'b0;
      if (VGA_REQ) begin
        MEM_ADDR <= VGA_ADDR;
      end else if (cpu_win) begin
        ptr_clr <= 1'b1;
        // An out-of-range write is acknowledged but never reaches memory.
        if (!cpu_oob) begin
          MEM_ADDR  <= CPU_ADDR;
          MEM_WDATA <= CPU_DATA;
          MEM_WE    <= 1'b1;
        end
      end else if (clr_win) begin
        ptr_clr   <= 1'b0;
        MEM_ADDR  <= clr_cnt;
        MEM_WDATA <= clr_colour;
        MEM_WE    <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (CLEAR_START) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            clr_colour <= CLEAR_COLOUR;
          end
        end
        CLEAR: begin
          if (clr_win) begin
            if (clr_cnt == LAST_ADDR) state <= IDLE;
            else clr_cnt <= clr_cnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FRAME_BUFFER_ARBITER_STATS_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) stall_cnt <= '0;
    else if (CPU_REQ && !cpu_win && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

  assign STALL_COUNT = stall_cnt;
`else
  assign STALL_COUNT = 16'h0000;
`endif

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: directed traffic, a synchronous memory model, and a per-cycle reference model
// that tracks slot ownership, shadow memory contents and expected read returns.
`timescale 1ns/1ps
module tb_frame_buffer_arbiter;
  localparam int AW = 15;
  localparam int DW = 12;
  localparam int DEPTH = 19200;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          VGA_REQ;
  logic [AW-1:0] VGA_ADDR;
  logic [DW-1:0] VGA_DATA;
  logic          VGA_VALID;
  logic          CPU_REQ;
  logic [AW-1:0] CPU_ADDR;
  logic [DW-1:0] CPU_DATA;
  logic          CPU_GNT;
  logic          CPU_ERR;
  logic          CLEAR_START;
  logic [DW-1:0] CLEAR_COLOUR;
  logic          CLEAR_BUSY;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_WE;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;
  logic [15:0]   STALL_COUNT;

  int n_checks = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  frame_buffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FB_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RESET(RESET),
    .VGA_REQ(VGA_REQ), .VGA_ADDR(VGA_ADDR), .VGA_DATA(VGA_DATA), .VGA_VALID(VGA_VALID),
    .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_DATA(CPU_DATA), .CPU_GNT(CPU_GNT), .CPU_ERR(CPU_ERR),
    .CLEAR_START(CLEAR_START), .CLEAR_COLOUR(CLEAR_COLOUR), .CLEAR_BUSY(CLEAR_BUSY),
    .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .STALL_COUNT(STALL_COUNT)
  );

  // Synchronous single-port memory with one cycle of read latency.
  logic [DW-1:0] mem [0:DEPTH-1] = '{default: '0};
  always @(posedge CLK) begin
    if (MEM_WE && int'(MEM_ADDR) < DEPTH) mem[MEM_ADDR] <= MEM_WDATA;
    MEM_RDATA <= (int'(MEM_ADDR) < DEPTH) ? mem[MEM_ADDR] : '0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: which agent owns each slot, what memory should hold, and when reads return.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  rd_t           rd_q[$];
  logic [DW-1:0] shadow [0:DEPTH-1] = '{default: '0};
  bit            m_busy;
  int            m_next;
  logic [DW-1:0] m_colour;
  bit            m_last_clr;
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;
  int            m_stall;

  initial begin : compare
    int cyc;
    bit busy_now, g_cpu, g_clr, oob, exp_v;
    cyc = 0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!RESET) begin
        rd_q.delete();
        m_busy = 0; m_next = 0; m_colour = '0; m_last_clr = 1;
        m_addr = '0; m_we = 0; m_wdata = '0; m_stall = 0;
        check("rst_vga_valid", 32'(VGA_VALID), 32'd0);
        check("rst_vga_data", 32'(VGA_DATA), 32'd0);
        check("rst_cpu_gnt", 32'(CPU_GNT), 32'd0);
        check("rst_cpu_err", 32'(CPU_ERR), 32'd0);
        check("rst_clear_busy", 32'(CLEAR_BUSY), 32'd0);
        check("rst_mem_addr", 32'(MEM_ADDR), 32'd0);
        check("rst_mem_we", 32'(MEM_WE), 32'd0);
        check("rst_mem_wdata", 32'(MEM_WDATA), 32'd0);
        check("rst_stall", 32'(STALL_COUNT), 32'd0);
      end else begin
        check("mem_we", 32'(MEM_WE), 32'(m_we));
        check("mem_addr", 32'(MEM_ADDR), 32'(m_addr));
        check("mem_wdata", 32'(MEM_WDATA), 32'(m_wdata));
        exp_v = (rd_q.size() > 0) && (rd_q[0].due == cyc);
        check("vga_valid", 32'(VGA_VALID), 32'(exp_v));
        if (exp_v) begin
          check("vga_data", 32'(VGA_DATA), 32'(rd_q[0].data));
          void'(rd_q.pop_front());
        end
        check("clear_busy", 32'(CLEAR_BUSY), 32'(m_busy));
`ifdef FRAME_BUFFER_ARBITER_STATS_EN
        check("stall_count", 32'(STALL_COUNT), 32'(m_stall));
`else
        check("stall_count", 32'(STALL_COUNT), 32'd0);
`endif
        // A read takes the slot outright; contested writes go to whichever writer did not go last.
        busy_now = m_busy;
        g_cpu = 0;
        g_clr = 0;
        if (!VGA_REQ) begin
          if (CPU_REQ && busy_now) begin
            if (m_last_clr) g_cpu = 1;
            else g_clr = 1;
          end else if (CPU_REQ) g_cpu = 1;
          else if (busy_now) g_clr = 1;
        end
        oob = int'(CPU_ADDR) >= DEPTH;
        check("cpu_gnt", 32'(CPU_GNT), 32'(g_cpu));
        check("cpu_err", 32'(CPU_ERR), 32'(g_cpu && oob));

        m_we = 0;
        if (VGA_REQ) begin
          m_addr = VGA_ADDR;
          rd_q.push_back('{due: cyc + 3, data: shadow[VGA_ADDR]});
        end else if (g_cpu) begin
          m_last_clr = 0;
          if (!oob) begin
            m_we = 1; m_addr = CPU_ADDR; m_wdata = CPU_DATA;
            shadow[CPU_ADDR] = CPU_DATA;
          end
        end else if (g_clr) begin
          m_last_clr = 1;
          m_we = 1; m_addr = AW'(m_next); m_wdata = m_colour;
          shadow[m_next] = m_colour;
          m_next++;
          if (m_next == DEPTH) m_busy = 0;
        end
        if (!busy_now && CLEAR_START) begin
          m_busy = 1; m_next = 0; m_colour = CLEAR_COLOUR;
        end
        if (CPU_REQ && !g_cpu && m_stall < 65535) m_stall++;
      end
    end
  end

  logic [AW-1:0] rd_tab [4] = '{15'h0010, 15'h0123, 15'h0010, 15'h0000};

  initial begin : stim
    int wcount, ccount, bad, writes;
    bit found;
    RESET = 1; VGA_REQ = 0; VGA_ADDR = '0; CPU_REQ = 0; CPU_ADDR = '0; CPU_DATA = '0;
    CLEAR_START = 0; CLEAR_COLOUR = '0;
    #2 RESET = 0;
    tick(); #2;
    check("reset_mem_we", 32'(MEM_WE), 32'd0);
    check("reset_busy", 32'(CLEAR_BUSY), 32'd0);
    tick(); RESET = 1;
    tick();

    // Lone CPU write, then read back through the display pipeline.
    CPU_REQ = 1; CPU_ADDR = 15'h0123; CPU_DATA = 12'hABC; #2;
    check("cpu_gnt_alone", 32'(CPU_GNT), 32'd1);
    check("cpu_err_alone", 32'(CPU_ERR), 32'd0);
    tick(); CPU_REQ = 0; #2;
    check("wr_we", 32'(MEM_WE), 32'd1);
    check("wr_addr", 32'(MEM_ADDR), 32'h123);
    check("wr_data", 32'(MEM_WDATA), 32'hABC);
    tick(); VGA_REQ = 1; VGA_ADDR = 15'h0123;
    tick(); VGA_REQ = 0; #2;
    check("rd_addr", 32'(MEM_ADDR), 32'h123);
    check("rd_we", 32'(MEM_WE), 32'd0);
    tick(); #2;
    check("rd_not_yet", 32'(VGA_VALID), 32'd0);
    tick(); #2;
    check("rd_valid", 32'(VGA_VALID), 32'd1);
    check("rd_data", 32'(VGA_DATA), 32'hABC);
    tick(); #2;
    check("rd_valid_pulse", 32'(VGA_VALID), 32'd0);

    // Read and CPU write in the same cycle: the read goes first.
    tick(); VGA_REQ = 1; VGA_ADDR = 15'h0050;
    CPU_REQ = 1; CPU_ADDR = 15'h0010; CPU_DATA = 12'hF00; #2;
    check("gnt_lost_to_read", 32'(CPU_GNT), 32'd0);
    tick(); VGA_REQ = 0; #2;
    check("gnt_after_read", 32'(CPU_GNT), 32'd1);
    check("read_addr_first", 32'(MEM_ADDR), 32'h050);
    tick(); CPU_REQ = 0; #2;
    check("cpu_wr_we", 32'(MEM_WE), 32'd1);
    check("cpu_wr_addr", 32'(MEM_ADDR), 32'h010);
    check("cpu_wr_data", 32'(MEM_WDATA), 32'hF00);

    // Back-to-back reads, fully pipelined.
    tick();
    for (int i = 0; i < 4; i++) begin
      VGA_REQ = 1; VGA_ADDR = rd_tab[i];
      if (i == 3) begin
        #2;
        check("pipe_valid0", 32'(VGA_VALID), 32'd1);
        check("pipe_data0", 32'(VGA_DATA), 32'hF00);
      end
      tick();
    end
    VGA_REQ = 0; #2;
    check("pipe_valid1", 32'(VGA_VALID), 32'd1);
    check("pipe_data1", 32'(VGA_DATA), 32'hABC);

    // Out-of-range CPU write is granted with an error and dropped.
    tick(); CPU_REQ = 1; CPU_ADDR = 15'd19200; CPU_DATA = 12'h555; #2;
    check("oob_gnt", 32'(CPU_GNT), 32'd1);
    check("oob_err", 32'(CPU_ERR), 32'd1);
    tick(); CPU_REQ = 0; #2;
    check("oob_no_write", 32'(MEM_WE), 32'd0);
    check("oob_addr_held", 32'(MEM_ADDR), 32'h000);

    // Full clear with no other traffic; a second start mid-clear must be ignored.
    tick(); CLEAR_START = 1; CLEAR_COLOUR = 12'h00F;
    tick(); CLEAR_START = 0; CLEAR_COLOUR = 12'hFFF; #2;
    check("clr_busy_start", 32'(CLEAR_BUSY), 32'd1);
    wcount = 0; ccount = 0; bad = 0;
    for (int g = 0; g < 19300; g++) begin
      tick();
      CLEAR_START = (wcount == 100);
      #2;
      ccount++;
      if (MEM_WE) begin
        if (int'(MEM_ADDR) != wcount || MEM_WDATA != 12'h00F) bad++;
        wcount++;
      end
      if (!CLEAR_BUSY) break;
    end
    CLEAR_START = 0;
    check("clr_busy_end", 32'(CLEAR_BUSY), 32'd0);
    check("clr_writes", 32'(wcount), 32'd19200);
    check("clr_cycles", 32'(ccount), 32'd19200);
    check("clr_bad_words", 32'(bad), 32'd0);

    // Clear against a continuously requesting CPU, with two reads injected.
    tick(); CLEAR_START = 1; CLEAR_COLOUR = 12'h0A0;
    tick(); CLEAR_START = 0; CPU_REQ = 1; CPU_ADDR = 15'h0200; CPU_DATA = 12'h0C0;
    wcount = 0;
    for (int g = 0; g < 40000; g++) begin
      VGA_REQ = (g == 1000 || g == 1001); VGA_ADDR = 15'h0123;
      #2;
      if (g == 1000) check("gnt_blocked_by_read", 32'(CPU_GNT), 32'd0);
      if (MEM_WE) wcount++;
      if (!CLEAR_BUSY) break;
      tick();
    end
    check("mix_busy_end", 32'(CLEAR_BUSY), 32'd0);
    check("mix_write_slots", 32'(wcount), 32'd38400);
    tick(); CPU_REQ = 0; VGA_REQ = 0;

    // Reset in the middle of a clear aborts it for good.
    tick(); CLEAR_START = 1; CLEAR_COLOUR = 12'h333;
    tick(); CLEAR_START = 0;
    found = 0;
    for (int g = 0; g < 1000; g++) begin
      #2;
      if (MEM_WE && MEM_ADDR == 15'd500) begin
        found = 1;
        break;
      end
      tick();
    end
    check("clr500_reached", 32'(found), 32'd1);
    RESET = 0; #1;
    check("abort_busy", 32'(CLEAR_BUSY), 32'd0);
    check("abort_mem_we", 32'(MEM_WE), 32'd0);
    check("abort_mem_addr", 32'(MEM_ADDR), 32'd0);
    check("abort_mem_wdata", 32'(MEM_WDATA), 32'd0);
    check("abort_vga_data", 32'(VGA_DATA), 32'd0);
    check("abort_stall", 32'(STALL_COUNT), 32'd0);
    tick(); tick(); RESET = 1;
    writes = 0;
    for (int g = 0; g < 50; g++) begin
      tick(); #2;
      if (MEM_WE || CLEAR_BUSY) writes++;
    end
    check("no_resume", 32'(writes), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
